// File: rtl/decoder_pkg.sv
// Shared types and default sizing for the row/column decoder-scanner.
package decoder_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } scan_mode_t;

    localparam int DEC_N_DEFAULT       = 32'd3;
    localparam int DEC_DWELL_W_DEFAULT = 32'd8;

endpackage

// File: rtl/decoder_scanner_decoder_n_to_2n.sv
// Combinational N-to-2^N one-hot decoder; all-zero when not enabled.
module decoder_n_to_2n
    import decoder_pkg::*;
#(
    parameter int N = DEC_N_DEFAULT
) (
    input  logic             ena,
    input  logic [N-1:0]     in,
    output logic [2**N-1:0]  out
);

    // One-hot select of the addressed line, blanked when disabled
    always_comb begin
        out = {(2**N){1'b0}};
        if (ena) begin
            out[in] = 1'b1;
        end else begin
            out = {(2**N){1'b0}};
        end
    end

endmodule

// File: rtl/decoder_scanner.sv
// Registered one-hot decoder with a self-timed scan mode for the LED matrix
// row/column selects. N must be at least 2.
module decoder_scanner
    import decoder_pkg::*;
#(
    parameter int N       = DEC_N_DEFAULT,
    parameter int DWELL_W = DEC_DWELL_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               mode,
    input  logic [N-1:0]       in,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2**N-1:0]    out,
    output logic [N-1:0]       index,
    output logic               wrap
);

    localparam int OUTPUTS = 2**N;
    localparam logic [N-1:0]       IDX_ZERO = {N{1'b0}};
    localparam logic [N-1:0]       IDX_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]       IDX_LAST = {N{1'b1}};
    localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

    scan_mode_t           mode_r;
    logic [N-1:0]         index_r;
    logic [DWELL_W-1:0]   cnt_r;
    logic                 wrap_r;
    logic [OUTPUTS-1:0]   out_r;

    logic [N-1:0]         index_next_s;
    logic [DWELL_W-1:0]   cnt_next_s;
    logic                 wrap_next_s;
    logic [OUTPUTS-1:0]   out_next_s;

    // Next line selection: direct load, scan entry restart, or dwell-timed step
    always_comb begin
        index_next_s = index_r;
        cnt_next_s   = cnt_r;
        wrap_next_s  = 1'b0;
        if (scan_mode_t'(mode) == MODE_DIRECT) begin
            index_next_s = in;
            cnt_next_s   = CNT_ZERO;
        end else if (mode_r == MODE_DIRECT) begin
            index_next_s = IDX_ZERO;
            cnt_next_s   = CNT_ZERO;
        end else if (cnt_r >= dwell) begin
            // >= so a lowered dwell advances at once instead of counting round
            cnt_next_s   = CNT_ZERO;
            index_next_s = index_r + IDX_ONE;
            wrap_next_s  = (index_r == IDX_LAST);
        end else begin
            cnt_next_s   = cnt_r + CNT_ONE;
        end
    end

    decoder_n_to_2n #(
        .N (N)
    ) u_dec (
        .ena (ena),
        .in  (index_next_s),
        .out (out_next_s)
    );

    // Scan state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r  <= MODE_DIRECT;
            index_r <= IDX_ZERO;
            cnt_r   <= CNT_ZERO;
            wrap_r  <= 1'b0;
            out_r   <= {OUTPUTS{1'b0}};
        end else begin
            mode_r  <= scan_mode_t'(mode);
            index_r <= index_next_s;
            cnt_r   <= cnt_next_s;
            wrap_r  <= wrap_next_s;
            out_r   <= out_next_s;
        end
    end

    assign out   = out_r;
    assign index = index_r;
    assign wrap  = wrap_r;

endmodule
